mp3_stream_fifo: RTL and testbench

- Producer end of the decoder's bitstream read interface (fifo_ren / fifo_datain) on mp3_dec_top2; replaces the bench-side word feeder in hardware.
- Accepts the MP3 file as a byte stream from a host via valid/ready and packs byte pairs big-endian into 16-bit words (first byte in [15:8]).
- Buffers words in a first-word-fall-through FIFO and serves them to the decoder.
- Also supports end-of-stream padding, flush, level reporting and sticky underflow detection.

---
 rtl/mp3_stream_pkg.sv | 13 +
 rtl/mp3_fwft_ram.sv | 26 ++
 rtl/mp3_stream_fifo.sv | 152 +++++++++++++++
 tb/tb_mp3_stream_fifo.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mp3_stream_pkg.sv
// Shared types and constants for the MP3 bitstream byte-to-word FIFO.
package mp3_stream_pkg;

    localparam int WORD_W = 16;

    localparam logic [7:0] PAD_BYTE = 8'h00;

    typedef enum logic {
        HI_WAIT = 1'b0,
        LO_WAIT = 1'b1
    } pack_state_e;

endpackage

// File: rtl/mp3_fwft_ram.sv
// Word storage for the stream FIFO: registered write port, combinational read port.
// Read data reflects a write on the cycle after the write edge; no backpressure.
module mp3_fwft_ram
    import mp3_stream_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [2**ADDR_W];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/mp3_stream_fifo.sv
// Packs host bytes big-endian into 16-bit words and serves them FWFT to the decoder.
// Zero added read latency; byte_ready drops when a word cannot complete or a padded eos write is stalled.
module mp3_stream_fifo
    import mp3_stream_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int AF_THRESH = 2**ADDR_W - 16
) (
    input  logic              CLK_I,
    input  logic              RST_I,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              byte_ready,
    input  logic              eos,
    input  logic              flush,
    input  logic              fifo_ren,
    output logic [15:0]       fifo_datain,
    output logic              fifo_empty,
    output logic              almost_full,
    output logic [ADDR_W:0]   level,
    output logic              underflow
);

    localparam logic [ADDR_W:0] DEPTH_LVL = (ADDR_W+1)'(2**ADDR_W);
    localparam logic [ADDR_W:0] AF_LVL    = (ADDR_W+1)'(AF_THRESH);

    pack_state_e       state_q, state_d;
    logic [7:0]        hi_q, hi_d;
    logic              eos_pend_q, eos_pend_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              underflow_q, underflow_d;

    logic              wr_en;
    logic [WORD_W-1:0] wr_word;
    logic [WORD_W-1:0] rd_word;
    logic              full;
    logic              accept;
    logic              pop;

    // Full uses the registered level only: a same-cycle pop never frees a slot early.
    assign full       = (level_q == DEPTH_LVL);
    assign fifo_empty = (level_q == '0);
    assign byte_ready = !RST_I && !flush && !eos_pend_q
                        && ((state_q == HI_WAIT) || !full);
    assign accept     = byte_valid && byte_ready;
    assign pop        = fifo_ren && !fifo_empty && !flush && !RST_I;

    always_comb begin
        state_d     = state_q;
        hi_d        = hi_q;
        eos_pend_d  = eos_pend_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        level_d     = level_q;
        underflow_d = underflow_q;
        wr_en       = 1'b0;
        wr_word     = '0;

        if (RST_I || flush) begin
            state_d     = HI_WAIT;
            hi_d        = '0;
            eos_pend_d  = 1'b0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            level_d     = '0;
            underflow_d = 1'b0;
        end else begin
            case (state_q)
                HI_WAIT: begin
                    if (accept) begin
                        if (eos && !full) begin
                            wr_en   = 1'b1;
                            wr_word = {byte_in, PAD_BYTE};
                        end else begin
                            // Lone high byte; a blocked eos is remembered for later padding.
                            hi_d       = byte_in;
                            state_d    = LO_WAIT;
                            eos_pend_d = eos;
                        end
                    end
                end
                LO_WAIT: begin
                    if (accept) begin
                        wr_en   = 1'b1;
                        wr_word = {hi_q, byte_in};
                        state_d = HI_WAIT;
                    end else if (eos || eos_pend_q) begin
                        if (!full) begin
                            wr_en      = 1'b1;
                            wr_word    = {hi_q, PAD_BYTE};
                            state_d    = HI_WAIT;
                            eos_pend_d = 1'b0;
                        end else begin
                            eos_pend_d = 1'b1;
                        end
                    end
                end
                default: state_d = HI_WAIT;
            endcase

            if (fifo_ren && fifo_empty) begin
                underflow_d = 1'b1;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            level_d = level_q + {{ADDR_W{1'b0}}, wr_en} - {{ADDR_W{1'b0}}, pop};
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            state_q     <= HI_WAIT;
            hi_q        <= '0;
            eos_pend_q  <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hi_q        <= hi_d;
            eos_pend_q  <= eos_pend_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            underflow_q <= underflow_d;
        end
    end

    mp3_fwft_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk_i   (CLK_I),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q),
        .wdata_i (wr_word),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_word)
    );

    assign fifo_datain = fifo_empty ? 16'h0000 : rd_word;
    assign almost_full = (level_q >= AF_LVL);
    assign level       = level_q;
    assign underflow   = underflow_q;

endmodule

// File: tb/tb_mp3_stream_fifo.sv
// Randomized and directed bench for mp3_stream_fifo against a queue-based stream model.
module tb_mp3_stream_fifo;

    localparam int ADDR_W = 3;
    localparam int AF_TH  = 6;
    localparam int DEPTH  = 2**ADDR_W;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              byte_ready;
    logic              eos = 1'b0;
    logic              flush = 1'b0;
    logic              fifo_ren = 1'b0;
    logic [15:0]       fifo_datain;
    logic              fifo_empty;
    logic              almost_full;
    logic [ADDR_W:0]   level;
    logic              underflow;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: stored words, pending high byte, sticky flags.
    logic [15:0] m_q [$];
    logic        m_hi_v = 1'b0;
    logic [7:0]  m_hi   = '0;
    logic        m_uf   = 1'b0;
    logic        m_ep   = 1'b0;

    mp3_stream_fifo #(
        .ADDR_W    (ADDR_W),
        .AF_THRESH (AF_TH)
    ) dut (
        .CLK_I       (clk),
        .RST_I       (rst),
        .byte_in     (byte_in),
        .byte_valid  (byte_valid),
        .byte_ready  (byte_ready),
        .eos         (eos),
        .flush       (flush),
        .fifo_ren    (fifo_ren),
        .fifo_datain (fifo_datain),
        .fifo_empty  (fifo_empty),
        .almost_full (almost_full),
        .level       (level),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic m_ready(input logic rs, input logic f);
        return !rs && !f && !m_ep && (!m_hi_v || m_q.size() < DEPTH);
    endfunction

    task automatic m_update(input logic v, input logic [7:0] b, input logic e,
                            input logic f, input logic r, input logic rs);
        int  sz;
        logic acc, do_pop;
        if (rs || f) begin
            m_q.delete();
            m_hi_v = 1'b0;
            m_uf   = 1'b0;
            m_ep   = 1'b0;
            return;
        end
        sz     = m_q.size();
        acc    = v && m_ready(rs, f);
        do_pop = r && (sz > 0);
        if (r && sz == 0) m_uf = 1'b1;
        if (acc && !m_hi_v) begin
            if (e && sz < DEPTH) begin
                m_q.push_back({b, 8'h00});
            end else begin
                m_hi   = b;
                m_hi_v = 1'b1;
                m_ep   = e;
            end
        end else if (acc) begin
            m_q.push_back({m_hi, b});
            m_hi_v = 1'b0;
        end else if (m_hi_v && (e || m_ep)) begin
            if (sz < DEPTH) begin
                m_q.push_back({m_hi, 8'h00});
                m_hi_v = 1'b0;
                m_ep   = 1'b0;
            end else begin
                m_ep = 1'b1;
            end
        end
        if (do_pop) void'(m_q.pop_front());
    endtask

    task automatic step(input logic v, input logic [7:0] b, input logic e,
                        input logic f, input logic r, input logic rs);
        @(negedge clk);
        byte_valid = v;
        byte_in    = b;
        eos        = e;
        flush      = f;
        fifo_ren   = r;
        rst        = rs;
        #1;
        if (!$isunknown(byte_ready) || rs)
            chk("byte_ready", byte_ready, m_ready(rs, f));
        @(posedge clk);
        m_update(v, b, e, f, r, rs);
        #1;
        chk("level", level, m_q.size());
        chk("empty", fifo_empty, m_q.size() == 0);
        chk("datain", fifo_datain, (m_q.size() > 0) ? m_q[0] : 16'h0000);
        chk("almost_full", almost_full, m_q.size() >= AF_TH);
        chk("underflow", underflow, m_uf);
    endtask

    task automatic push(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pop1();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("rst_level", level, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_datain", fifo_datain, 16'h0000);

        // Byte packing and FWFT pops
        push(8'h49); push(8'h44); push(8'h33); push(8'h03);
        chk("pk_level", level, 2);
        chk("pk_head", fifo_datain, 16'h4944);
        chk("pk_empty", fifo_empty, 0);
        pop1();
        chk("pk_head2", fifo_datain, 16'h3303);
        pop1();
        chk("pk_level0", level, 0);
        chk("pk_datain0", fifo_datain, 16'h0000);

        // eos pads an odd byte
        push(8'hFF); push(8'hFB); push(8'hAA);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("eos_level", level, 2);
        chk("eos_head", fifo_datain, 16'hFFFB);
        pop1();
        chk("eos_pad", fifo_datain, 16'hAA00);
        pop1();

        // Fill to full, almost_full boundary, wrap
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h10 + i));
            if (i == 9)  chk("af_lo", almost_full, 0);
            if (i == 11) chk("af_hi", almost_full, 1);
        end
        chk("full_level", level, 8);
        push(8'hA0);
        chk("full_rdy0", byte_ready, 0);
        push(8'hA1);
        chk("full_hold", level, 8);
        pop1();
        chk("full_rdy1", byte_ready, 1);
        push(8'hA1);
        chk("wrap_level", level, 8);
        chk("wrap_head", fifo_datain, 16'h1213);
        for (int i = 0; i < 7; i++) pop1();
        chk("wrap_word", fifo_datain, 16'hA0A1);
        pop1();

        // Underflow, then flush clears it along with a pending high byte
        pop1();
        chk("uf_set", underflow, 1);
        chk("uf_datain", fifo_datain, 16'h0000);
        push(8'h55); push(8'h66);
        chk("uf_sticky", underflow, 1);
        chk("uf_push", fifo_datain, 16'h5566);
        push(8'h99);
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("fl_uf", underflow, 0);
        chk("fl_level", level, 0);
        push(8'h12); push(8'h34);
        chk("fl_hi", fifo_datain, 16'h1234);
        pop1();

        // Reset mid-stream with level 5 and a pending high byte
        for (int i = 0; i < 11; i++) push(8'(8'h20 + i));
        chk("mid_level", level, 5);
        step(1'b1, 8'hFF, 1'b1, 1'b0, 1'b1, 1'b1);
        chk("mid_rst_level", level, 0);
        chk("mid_rst_empty", fifo_empty, 1);
        push(8'h77); push(8'h88);
        chk("mid_rst_hi", fifo_datain, 16'h7788);

        // Random traffic: fill-biased phase then drain-biased phase
        for (int i = 0; i < 800; i++) begin
            logic v, e, f, r, rs;
            logic [7:0] b;
            v  = ($urandom % 10) < 8;
            b  = 8'($urandom);
            e  = ($urandom % 20) == 0;
            r  = ($urandom % 10) < ((i < 400) ? 3 : 6);
            f  = ($urandom % 80) == 0;
            rs = ($urandom % 150) == 0;
            step(v, b, e, f, r, rs);
        end

        // Saturated push+pop at full
        for (int i = 0; i < 120; i++) begin
            step(1'b1, 8'($urandom), 1'b0, 1'b0, (i >= 20), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
